// File: rtl/tile_console_writer_pkg.sv
// Shared constants and encodings for the tile console writer.
package tile_console_writer_pkg;

    localparam int COLS = 32;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DECODE      = 3'd1,
        ST_PUT         = 3'd2,
        ST_SCROLL_RD   = 3'd3,
        ST_SCROLL_WR   = 3'd4,
        ST_SCROLL_FILL = 3'd5,
        ST_CLEAR       = 3'd6
    } state_e;

    // Cursor update requested by the writer FSM for the current cycle.
    typedef enum logic [2:0] {
        CUR_HOLD    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_BACK    = 3'd3,
        CUR_HOME    = 3'd4,
        CUR_LAST    = 3'd5
    } cur_cmd_e;

endpackage

// File: rtl/console_cursor.sv
// Hardware text cursor: row/column registers with advance, newline,
// backspace and home / last-row loads. On the bottom row a newline only
// resets the column; the writer handles the scroll.
module console_cursor
    import tile_console_writer_pkg::*;
#(
    parameter int ROWS = 30
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  cur_cmd_e cmd_i,
    output logic [4:0] row_o,
    output logic [4:0] col_o,
    output logic     at_bottom_o
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;

    assign at_bottom_o = (row_q == LAST_ROW);
    assign row_o       = row_q;
    assign col_o       = col_q;

    // Next cursor position for the requested command.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        case (cmd_i)
            CUR_ADVANCE: begin
                if (col_q != LAST_COL) begin
                    col_d = col_q + 5'd1;
                end else begin
                    col_d = 5'd0;
                    if (!at_bottom_o) row_d = row_q + 5'd1;
                end
            end
            CUR_NEWLINE: begin
                col_d = 5'd0;
                if (!at_bottom_o) row_d = row_q + 5'd1;
            end
            CUR_BACK: begin
                if (col_q != 5'd0) col_d = col_q - 5'd1;
            end
            CUR_HOME: begin
                row_d = 5'd0;
                col_d = 5'd0;
            end
            CUR_LAST: begin
                row_d = LAST_ROW;
                col_d = 5'd0;
            end
            default: ;
        endcase
    end

    // Cursor registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            row_q <= 5'd0;
            col_q <= 5'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/tile_console_writer.sv
// Byte-stream console writer for the 32-column tile RAM. Prints bytes at
// the cursor, handles BS/LF/FF, scrolls by row copy and clears by sweep.
// RAM lines only advance on cycles where the arbiter grants the slot.
module tile_console_writer
    import tile_console_writer_pkg::*;
#(
    parameter int         ROWS = 30,
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       ram_grant,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata,
    output logic [4:0] cursor_row,
    output logic [4:0] cursor_col,
    output logic       busy
);

    localparam logic [9:0] CELLS_LAST = 10'(ROWS * COLS - 1);
    localparam logic [9:0] COPY_LAST  = 10'((ROWS - 1) * COLS - 1);
    localparam logic [9:0] FILL_FIRST = 10'((ROWS - 1) * COLS);
    localparam logic [4:0] LAST_COL   = 5'(COLS - 1);

    state_e     state_q;
    logic [7:0] byte_q;
    logic [7:0] buf_q;
    logic [9:0] idx_q;
    cur_cmd_e   cur_cmd;
    logic       at_bottom;

    console_cursor #(.ROWS(ROWS)) u_cursor (
        .clk_i      (clk),
        .reset_i    (reset),
        .cmd_i      (cur_cmd),
        .row_o      (cursor_row),
        .col_o      (cursor_col),
        .at_bottom_o(at_bottom)
    );

    assign in_ready = (state_q == ST_IDLE) && !reset;
    assign busy     = (state_q != ST_IDLE);

    // Cursor command: decode-time controls, and end-of-step updates that
    // only fire on a granted RAM cycle.
    always_comb begin
        cur_cmd = CUR_HOLD;
        case (state_q)
            ST_DECODE: begin
                if (byte_q == CH_BS)      cur_cmd = CUR_BACK;
                else if (byte_q == CH_LF) cur_cmd = CUR_NEWLINE;
            end
            ST_PUT:         if (ram_grant) cur_cmd = CUR_ADVANCE;
            ST_SCROLL_FILL: if (ram_grant && idx_q == CELLS_LAST) cur_cmd = CUR_LAST;
            ST_CLEAR:       if (ram_grant && idx_q == CELLS_LAST) cur_cmd = CUR_HOME;
            default: ;
        endcase
    end

    // RAM address/data/strobe; the strobe is gated by grant so an
    // ungranted cycle is a pure stall.
    always_comb begin
        ram_addr  = {cursor_row, cursor_col};
        ram_wdata = FILL;
        ram_we    = 1'b0;
        case (state_q)
            ST_PUT: begin
                ram_wdata = byte_q;
                ram_we    = ram_grant;
            end
            ST_SCROLL_RD: ram_addr = idx_q + 10'd32;
            ST_SCROLL_WR: begin
                ram_addr  = idx_q;
                ram_wdata = buf_q;
                ram_we    = ram_grant;
            end
            ST_SCROLL_FILL, ST_CLEAR: begin
                ram_addr = idx_q;
                ram_we   = ram_grant;
            end
            default: ;
        endcase
    end

    // Writer FSM: byte latch, decode, put, scroll copy/fill and clear sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
            buf_q   <= 8'h00;
            idx_q   <= 10'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        byte_q  <= in_data;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    idx_q <= 10'd0;
                    case (byte_q)
                        CH_BS:   state_q <= ST_IDLE;
                        CH_LF:   state_q <= at_bottom ? ST_SCROLL_RD : ST_IDLE;
                        CH_FF:   state_q <= ST_CLEAR;
                        default: state_q <= ST_PUT;
                    endcase
                end
                ST_PUT: begin
                    if (ram_grant) begin
                        idx_q   <= 10'd0;
                        state_q <= (cursor_col == LAST_COL && at_bottom) ? ST_SCROLL_RD : ST_IDLE;
                    end
                end
                ST_SCROLL_RD: begin
                    if (ram_grant) begin
                        buf_q   <= ram_rdata;
                        state_q <= ST_SCROLL_WR;
                    end
                end
                ST_SCROLL_WR: begin
                    if (ram_grant) begin
                        if (idx_q == COPY_LAST) begin
                            idx_q   <= FILL_FIRST;
                            state_q <= ST_SCROLL_FILL;
                        end else begin
                            idx_q   <= idx_q + 10'd1;
                            state_q <= ST_SCROLL_RD;
                        end
                    end
                end
                ST_SCROLL_FILL, ST_CLEAR: begin
                    if (ram_grant) begin
                        if (idx_q == CELLS_LAST) state_q <= ST_IDLE;
                        else                     idx_q   <= idx_q + 10'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_console_writer.sv
// Directed bench for tile_console_writer with a behavioural tile RAM.
module tb_tile_console_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       ram_grant = 1'b1;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic [4:0] cursor_row, cursor_col;
    logic       busy;

    logic [7:0] mem [0:1023];
    int         nwr = 0;
    int         bad = 0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic       tog = 1'b0;

    int errors = 0;
    int checks = 0;

    tile_console_writer #(.ROWS(30), .FILL(8'h00)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ram_grant(ram_grant), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];

    // RAM model plus protocol monitor: writes without grant or past the
    // visible area are counted as violations.
    always @(posedge clk) begin
        if (ram_we) begin
            if (!ram_grant || ram_addr >= 10'd960) bad = bad + 1;
            mem[ram_addr] = ram_wdata;
            nwr = nwr + 1;
            last_addr = ram_addr;
            last_data = ram_wdata;
        end
    end

    always @(negedge clk) if (tog) ram_grant <= ~ram_grant;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Send one byte and wait until in_ready returns; low = cycles spent busy.
    task automatic send(input logic [7:0] b, output int low);
        int t;
        t = 0;
        while (!in_ready && t < 5000) begin @(negedge clk); t++; end
        if (!in_ready) chk("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        low = 0;
        while (!in_ready && low < 5000) begin low++; @(negedge clk); end
        if (!in_ready) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] d;
        int row, col, nw, addr, data, low;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int low, n0, cnt, t;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // low = -1 means latency is not compared for that record.
        tbl[0]  = '{8'h41, 0, 1, 1, 0,  8'h41, 2};
        tbl[1]  = '{8'h42, 0, 2, 1, 1,  8'h42, 2};
        tbl[2]  = '{8'h08, 0, 1, 0, 0,  0,    -1};
        tbl[3]  = '{8'h08, 0, 0, 0, 0,  0,    -1};
        tbl[4]  = '{8'h08, 0, 0, 0, 0,  0,    -1};
        tbl[5]  = '{8'h43, 0, 1, 1, 0,  8'h43, 2};
        tbl[6]  = '{8'h0A, 1, 0, 0, 0,  0,    -1};
        tbl[7]  = '{8'h44, 1, 1, 1, 32, 8'h44, 2};
        tbl[8]  = '{8'h45, 1, 2, 1, 33, 8'h45, 2};
        tbl[9]  = '{8'h46, 1, 3, 1, 34, 8'h46, 2};
        tbl[10] = '{8'h08, 1, 2, 0, 0,  0,    -1};
        tbl[11] = '{8'h0A, 2, 0, 0, 0,  0,    -1};

        // Reset state while reset is held.
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_row", cursor_row, 0);
        chk("rst_col", cursor_col, 0);
        do_reset();
        chk("post_rst_in_ready", in_ready, 1);

        // Table of single-byte transactions from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            n0 = nwr;
            send(tbl[i].d, low);
            chk($sformatf("v%0d_row", i), cursor_row, tbl[i].row);
            chk($sformatf("v%0d_col", i), cursor_col, tbl[i].col);
            chk($sformatf("v%0d_nwr", i), nwr - n0, tbl[i].nw);
            if (tbl[i].nw > 0) begin
                chk($sformatf("v%0d_addr", i), last_addr, tbl[i].addr);
                chk($sformatf("v%0d_data", i), last_data, tbl[i].data);
            end
            if (tbl[i].low >= 0) chk($sformatf("v%0d_busy_cycles", i), low, tbl[i].low);
        end

        // 32 printable bytes fill row 0 and wrap to row 1.
        do_reset();
        n0 = nwr;
        for (int i = 0; i < 32; i++) send(8'h20 + 8'(i), low);
        cnt = 0;
        for (int i = 0; i < 32; i++) if (mem[i] != 8'h20 + 8'(i)) cnt++;
        chk("row0_bad_cells", cnt, 0);
        chk("row0_writes", nwr - n0, 32);
        chk("wrap_row", cursor_row, 1);
        chk("wrap_col", cursor_col, 0);

        // Alternating grant during a PUT and a CLEAR.
        do_reset();
        for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
        tog = 1'b1;
        n0 = nwr;
        send(8'h5A, low);
        chk("tog_put_writes", nwr - n0, 1);
        chk("tog_put_data", mem[0], 8'h5A);
        chk("tog_put_col", cursor_col, 1);
        n0 = nwr;
        send(8'h0C, low);
        tog = 1'b0;
        @(negedge clk);
        ram_grant = 1'b1;
        chk("clear_writes", nwr - n0, 960);
        cnt = 0;
        for (int i = 0; i < 960; i++) if (mem[i] != 8'h00) cnt++;
        chk("clear_bad_cells", cnt, 0);
        chk("clear_row", cursor_row, 0);
        chk("clear_col", cursor_col, 0);
        chk("clear_untouched_cell", mem[960], 8'hAA);

        // Scroll from the bottom row with grant held high.
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A, low);
        for (int i = 0; i < 5; i++) send(8'h78, low);
        chk("pre_scroll_row", cursor_row, 29);
        chk("pre_scroll_col", cursor_col, 5);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 32; c++) mem[r * 32 + c] = 8'(r);
        n0 = nwr;
        send(8'h0A, low);
        chk("scroll_busy_cycles", low, 1 + 1888);
        chk("scroll_writes", nwr - n0, 960);
        for (int r = 0; r < 30; r++) begin
            cnt = 0;
            for (int c = 0; c < 32; c++)
                if (mem[r * 32 + c] != ((r < 29) ? 8'(r + 1) : 8'h00)) cnt++;
            chk($sformatf("scroll_row%0d_bad_cells", r), cnt, 0);
        end
        chk("scroll_row", cursor_row, 29);
        chk("scroll_col", cursor_col, 0);

        // Reset in the middle of a scroll copy.
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A, low);
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!(ram_we && ram_addr == 10'd100) && t < 5000) begin @(negedge clk); t++; end
        chk("reach_idx100", int'(ram_we && ram_addr == 10'd100), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_row", cursor_row, 0);
        chk("abort_col", cursor_col, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_in_ready_in_reset", in_ready, 0);
        n0 = nwr;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        chk("abort_no_writes", nwr - n0, 0);

        chk("we_violations", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
